// File: rtl/sram_march_tester.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_tester
// Brief    : Four-phase (W P / R P / W ~P / R ~P) SRAM tester with selectable
//            data patterns, first-failure capture and a saturating error count.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sram_march_tester #(
    parameter int          AW        = 21,
    parameter int          DW        = 8,
    parameter int unsigned ADDR_LAST = 2**AW - 1,
    parameter int          ACC_CYC   = 2,
    parameter int          CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          stop_on_error,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          sram_oe,
    output logic          sram_we_n,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [1:0]    phase,
    output logic [CW-1:0] error_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_expected,
    output logic [DW-1:0] fail_got
);

    localparam int              c_nch       = (AW + DW - 1) / DW;
    localparam int              c_cntw      = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int              c_shw       = $clog2(DW);
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(ACC_CYC - 1);
    localparam logic [AW-1:0]   c_addr_last = AW'(ADDR_LAST);
    localparam logic [CW-1:0]   c_err_max   = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SETUP = 3'd1,
        S_WR_PULSE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_CHECK = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Data pattern for one address; inv selects the complement used in phases 2/3.
    function automatic logic [DW-1:0] f_pattern(input logic [AW-1:0] a,
                                                input logic [1:0]    m,
                                                input logic          inv);
        logic [c_nch*DW-1:0] pad;
        logic [DW-1:0]       v;
        logic [DW-1:0]       chk;
        pad          = '0;
        pad[AW-1:0]  = a;
        v            = '0;
        chk          = '0;
        case (m)
            2'd0: begin
                for (int i = 0; i < c_nch; i++) begin
                    v = v ^ pad[i*DW +: DW];
                end
            end
            2'd1: begin
                for (int i = 0; i < DW; i++) begin
                    chk[i] = 1'((i % 2) == 1);
                end
                v = chk ^ {DW{a[0]}};
            end
            2'd2:    v = DW'(1) << pad[c_shw-1:0];
            default: v = '1;
        endcase
        return inv ? ~v : v;
    endfunction

    state_t              r_state;
    logic [AW-1:0]       r_addr;
    logic [c_cntw-1:0]   r_cnt;
    logic [1:0]          r_mode;
    logic [DW-1:0]       r_rd_data;

    state_t              w_state_nxt;
    logic [AW-1:0]       w_addr_nxt;
    logic [1:0]          w_phase_nxt;
    logic [c_cntw-1:0]   w_cnt_nxt;
    logic [1:0]          w_mode_nxt;
    logic [DW-1:0]       w_rd_nxt;
    logic [CW-1:0]       w_err_nxt;
    logic [AW-1:0]       w_fail_addr_nxt;
    logic [DW-1:0]       w_fail_exp_nxt;
    logic [DW-1:0]       w_fail_got_nxt;
    logic                w_step;
    logic                w_wr_nxt;
    logic [DW-1:0]       w_expected;

    assign w_expected = f_pattern(r_addr, r_mode, phase[1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_mode        <= '0;
            r_rd_data     <= '0;
            phase         <= '0;
            error_count   <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_got      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            sram_a        <= '0;
            sram_dout     <= '0;
            sram_oe       <= 1'b0;
            sram_we_n     <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mode        <= w_mode_nxt;
            r_rd_data     <= w_rd_nxt;
            phase         <= w_phase_nxt;
            error_count   <= w_err_nxt;
            fail_addr     <= w_fail_addr_nxt;
            fail_expected <= w_fail_exp_nxt;
            fail_got      <= w_fail_got_nxt;
            busy          <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            done          <= (w_state_nxt == S_DONE);
            pass          <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
            sram_a        <= w_addr_nxt;
            sram_dout     <= w_wr_nxt ? f_pattern(w_addr_nxt, w_mode_nxt, w_phase_nxt[1]) : '0;
            sram_oe       <= w_wr_nxt;
            sram_we_n     <= (w_state_nxt != S_WR_PULSE);
        end
    end

    // Bus outputs are decoded from the next state so they are valid for the
    // whole of the cycle spent in that state.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_phase_nxt     = phase;
        w_cnt_nxt       = r_cnt;
        w_mode_nxt      = r_mode;
        w_rd_nxt        = r_rd_data;
        w_err_nxt       = error_count;
        w_fail_addr_nxt = fail_addr;
        w_fail_exp_nxt  = fail_expected;
        w_fail_got_nxt  = fail_got;
        w_step          = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_WR_SETUP;
                    w_addr_nxt      = '0;
                    w_phase_nxt     = 2'd0;
                    w_cnt_nxt       = '0;
                    w_mode_nxt      = mode;
                    w_err_nxt       = '0;
                    w_fail_addr_nxt = '0;
                    w_fail_exp_nxt  = '0;
                    w_fail_got_nxt  = '0;
                end
            end
            S_WR_SETUP: begin
                w_state_nxt = S_WR_PULSE;
                w_cnt_nxt   = '0;
            end
            S_WR_PULSE: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_WR_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WR_HOLD: begin
                w_step = 1'b1;
            end
            S_RD_WAIT: begin
                if (r_cnt == c_cnt_last) begin
                    w_rd_nxt    = sram_din;
                    w_state_nxt = S_RD_CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_CHECK: begin
                w_step = 1'b1;
                if (r_rd_data != w_expected) begin
                    if (error_count != c_err_max) begin
                        w_err_nxt = error_count + 1'b1;
                    end
                    // A zero count means no earlier mismatch in this run.
                    if (error_count == '0) begin
                        w_fail_addr_nxt = r_addr;
                        w_fail_exp_nxt  = w_expected;
                        w_fail_got_nxt  = r_rd_data;
                    end
                    if (stop_on_error) begin
                        w_step      = 1'b0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_step) begin
            w_cnt_nxt = '0;
            if (r_addr == c_addr_last) begin
                w_addr_nxt = '0;
                if (phase == 2'd3) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_phase_nxt = phase + 2'd1;
                    w_state_nxt = w_phase_nxt[0] ? S_RD_WAIT : S_WR_SETUP;
                end
            end else begin
                w_addr_nxt  = r_addr + 1'b1;
                w_state_nxt = phase[0] ? S_RD_WAIT : S_WR_SETUP;
            end
        end

        w_wr_nxt = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                   (w_state_nxt == S_WR_HOLD);
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_tester
// Brief    : Directed and randomised bench with a fault-injectable SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_tester;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int LAST = 15;
    localparam int ACC  = 2;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          stop_on_error = 1'b0;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] sram_din;
    logic          sram_oe;
    logic          sram_we_n;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    phase;
    logic [CW-1:0] error_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_expected;
    logic [DW-1:0] fail_got;

    int n_checks = 0;
    int n_err    = 0;
    int last_cyc = 0;

    // Fault kinds: 0 none, 1 stuck-at-1, 2 stuck-at-0 (data bit f_bit at f_addr),
    // 3 address bit f_bit ignored by the array.
    int f_kind = 0;
    int f_addr = 0;
    int f_bit  = 0;

    sram_march_tester #(
        .AW(AW), .DW(DW), .ADDR_LAST(LAST), .ACC_CYC(ACC), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .stop_on_error(stop_on_error), .sram_a(sram_a), .sram_dout(sram_dout),
        .sram_din(sram_din), .sram_oe(sram_oe), .sram_we_n(sram_we_n),
        .busy(busy), .done(done), .pass(pass), .phase(phase),
        .error_count(error_count), .fail_addr(fail_addr),
        .fail_expected(fail_expected), .fail_got(fail_got)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    logic [AW-1:0] a_eff;
    logic [DW-1:0] rd;

    always_comb begin
        a_eff = sram_a;
        if (f_kind == 3) a_eff[f_bit] = 1'b0;
        rd = mem[a_eff];
        if (f_kind == 1 && int'(sram_a) == f_addr) rd[f_bit] = 1'b1;
        if (f_kind == 2 && int'(sram_a) == f_addr) rd[f_bit] = 1'b0;
        sram_din = rd;
    end

    always_ff @(posedge clk) begin
        if (!sram_we_n) mem[a_eff] <= sram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a, input logic [1:0] m, input logic inv);
        logic [DW-1:0] v;
        v = '0;
        case (m)
            2'd0: for (int s = 0; s < AW; s += DW) v = v ^ DW'((a >> s) & 255);
            2'd1: v = (a % 2 == 1) ? 8'h55 : 8'hAA;
            2'd2: v = DW'(1 << (a % DW));
            default: v = 8'hFF;
        endcase
        return inv ? ~v : v;
    endfunction

    // Reference: walk the march over an array copy of the faulty SRAM.
    task automatic model(input logic [1:0] m, input logic stop,
                         output int e_cyc, output int e_err, output int e_fa,
                         output int e_fe, output int e_fg, output int e_ph,
                         output int e_wr);
        logic [DW-1:0] mm [16];
        logic [AW-1:0] ea;
        logic [DW-1:0] ev;
        logic [DW-1:0] got;
        bit halted;
        halted = 0;
        e_cyc = 0; e_err = 0; e_fa = 0; e_fe = 0; e_fg = 0; e_ph = 3; e_wr = 0;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a <= LAST; a++) begin
                if (!halted) begin
                    ev = pat(a, m, p >= 2);
                    ea = AW'(a);
                    if (f_kind == 3) ea[f_bit] = 1'b0;
                    if (p % 2 == 0) begin
                        mm[ea] = ev;
                        e_wr++;
                        e_cyc += ACC + 2;
                    end else begin
                        got = mm[ea];
                        if (f_kind == 1 && a == f_addr) got[f_bit] = 1'b1;
                        if (f_kind == 2 && a == f_addr) got[f_bit] = 1'b0;
                        e_cyc += ACC + 1;
                        if (got != ev) begin
                            if (e_err == 0) begin
                                e_fa = a; e_fe = int'(ev); e_fg = int'(got);
                            end
                            e_err++;
                            if (stop) begin
                                halted = 1;
                                e_ph = p;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] m,
                                 input logic stop, input int extra_at);
        int e_cyc, e_err, e_fa, e_fe, e_fg, e_ph, e_wr;
        int cyc, lowlen, viol, pulses;
        model(m, stop, e_cyc, e_err, e_fa, e_fe, e_fg, e_ph, e_wr);
        mode = m;
        stop_on_error = stop;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0; lowlen = 0; viol = 0; pulses = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_clr_err"}, 32'(error_count), 0);
                chk({tag, "_clr_fail"}, {12'd0, fail_addr, fail_expected, fail_got}, 0);
                chk({tag, "_clr_done"}, 32'(done), 0);
            end
            start = (cyc == extra_at);
            if (!sram_we_n) begin
                lowlen++;
                if (!sram_oe) viol++;
            end else if (lowlen != 0) begin
                if (lowlen != ACC) viol++;
                pulses++;
                lowlen = 0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        last_cyc = cyc;
        chk({tag, "_busy_cycles"}, cyc, e_cyc);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_pass"}, 32'(pass), 32'(e_err == 0));
        chk({tag, "_err_cnt"}, 32'(error_count), e_err);
        chk({tag, "_phase"}, 32'(phase), e_ph);
        chk({tag, "_fail_addr"}, 32'(fail_addr), e_fa);
        chk({tag, "_fail_exp"}, 32'(fail_expected), e_fe);
        chk({tag, "_fail_got"}, 32'(fail_got), e_fg);
        chk({tag, "_we_viol"}, viol, 0);
        chk({tag, "_we_pulses"}, pulses, e_wr);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_bus", {19'd0, sram_oe, sram_a, sram_dout}, 0);
        chk("rst_flags", {28'd0, busy, done, pass, 1'b0}, 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_err", 32'(error_count), 0);
        chk("rst_fail", {12'd0, fail_addr, fail_expected, fail_got}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good SRAM, stray start during busy.
        f_kind = 0;
        run_and_check("s1", 2'd0, 1'b0, 10);
        chk("s1_cyc224", last_cyc, 224);
        chk("s1_phase3", 32'(phase), 3);

        // Stuck-at-1 on bit 3 of address 5, checkerboard.
        f_kind = 1; f_addr = 5; f_bit = 3;
        run_and_check("s2", 2'd1, 1'b0, -1);
        chk("s2_fa", 32'(fail_addr), 5);
        chk("s2_fe", 32'(fail_expected), 32'h55);
        chk("s2_fg", 32'(fail_got), 32'h5D);
        chk("s2_err", 32'(error_count), 1);

        // Same fault, stop at first mismatch.
        run_and_check("s3", 2'd1, 1'b1, -1);
        chk("s3_cyc", last_cyc, 16 * (ACC + 2) + 6 * (ACC + 1));
        chk("s3_phase", 32'(phase), 1);

        // Array ignores A2, address fold.
        f_kind = 3; f_bit = 2;
        run_and_check("s4", 2'd0, 1'b0, -1);
        chk("s4_fg", 32'(fail_got), 32'h04);
        chk("s4_err", 32'(error_count), 16);

        // Restart from DONE on a good SRAM.
        f_kind = 0;
        run_and_check("s6", 2'd0, 1'b0, -1);

        // Reset while a write strobe is active.
        mode = 2'd0; stop_on_error = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 100 && sram_we_n; i++) @(negedge clk);
        chk("s5_we_seen", 32'(sram_we_n), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5_we_n", 32'(sram_we_n), 1);
        chk("s5_oe", 32'(sram_oe), 0);
        chk("s5_busy_done", {30'd0, busy, done}, 0);
        chk("s5_err", 32'(error_count), 0);
        run_and_check("s5_rerun", 2'd0, 1'b0, -1);
        chk("s5_cyc224", last_cyc, 224);

        // Randomised faults, modes and stop behaviour.
        for (int r = 0; r < 8; r++) begin
            f_kind = int'($urandom_range(0, 3));
            f_addr = int'($urandom_range(0, LAST));
            f_bit  = (f_kind == 3) ? int'($urandom_range(0, AW - 1))
                                   : int'($urandom_range(0, DW - 1));
            run_and_check($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
